// File: rtl/drbg_pkg.sv
// Shared definitions for the DRBG producer/consumer pair.
// Holds the producer FSM state encoding and the default block size and
// reseed interval, so producer and consumer agree on both.
package drbg_pkg;

    // Width of one generated block, in bits.
    localparam int DRBG_DATA_WIDTH_DEF      = 256;

    // Blocks that may be delivered before a reseed is mandatory.
    localparam int DRBG_RESEED_INTERVAL_DEF = 1024;

    // Producer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_HASH = 3'd2,
        ST_READY     = 3'd3,
        ST_DELIVER   = 3'd4,
        ST_RESEED    = 3'd5
    } drbg_state_t;

    // Width of a counter that must hold every value 0..limit inclusive.
    function automatic int drbg_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/drbg_block_reg.sv
// Purpose: one-deep holding slot for a hash digest awaiting delivery.
// Latency: load/clear take effect on the next clock edge.
// Backpressure: none; the owning FSM decides when to load and when to clear.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_load, i_dat  capture i_dat into the slot and mark it valid
//   i_clear        discard the slot (data zeroed, valid dropped); wins over i_load
//   o_dat, o_vld   slot contents and its valid flag
module drbg_block_reg
    import drbg_pkg::*;
#(
    parameter int DATA_WIDTH = DRBG_DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_dat,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_vld
);

    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_vld;

    // Clearing also zeroes the data so a consumed or discarded block never
    // lingers in the slot where it could be handed out a second time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dat <= '0;
            r_vld <= 1'b0;
        end else if (i_clear) begin
            r_dat <= '0;
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_dat <= i_dat;
            r_vld <= 1'b1;
        end
    end

    assign o_dat = r_dat;
    assign o_vld = r_vld;

endmodule

// File: rtl/drbg_producer.sv
// Purpose: request-driven DRBG block producer wrapping an external hash core.
// Latency: data_valid 2 cycles after hash_done; with prefetch, 2 cycles after need_next in READY.
// Backpressure: one-deep request flag; busy low only when a ready block waits unrequested.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   need_next                 single-cycle block request from the consumer
//   data_out, data_valid      delivered block (held until the next delivery) and its strobe
//   busy                      high unless a block is ready and no request is outstanding
//   hash_start                single-cycle pulse launching one hash computation
//   hash_digest, hash_done    hash core result and its strobe (ignored outside WAIT_HASH)
//   reseed_req, reseed_ack    reseed handshake: level request, pulse acknowledge
//   block_count               blocks delivered since the last reseed (saturating)
//
// Build option: define DRBG_PRODUCER_PREFETCH_EN to keep one block hashed
// ahead of demand; by default a hash is only started for a pending request.
module drbg_producer
    import drbg_pkg::*;
#(
    parameter int DATA_WIDTH      = DRBG_DATA_WIDTH_DEF,
    parameter int RESEED_INTERVAL = DRBG_RESEED_INTERVAL_DEF,
    localparam int CNT_W          = drbg_cnt_w(RESEED_INTERVAL)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  need_next,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  hash_start,
    input  logic [DATA_WIDTH-1:0] hash_digest,
    input  logic                  hash_done,
    output logic                  reseed_req,
    input  logic                  reseed_ack,
    output logic [CNT_W-1:0]      block_count
);

`ifdef DRBG_PRODUCER_PREFETCH_EN
    localparam bit PREFETCH_EN = 1'b1;
`else
    localparam bit PREFETCH_EN = 1'b0;
`endif

    drbg_state_t           r_state;
    drbg_state_t           w_next_state;
    logic                  r_pending;
    logic [CNT_W-1:0]      r_block_count;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_at_limit;
    logic                  w_want_hash;
    logic                  w_slot_load;
    logic                  w_slot_clear;
    logic                  w_slot_vld;
    logic [DATA_WIDTH-1:0] w_slot_dat;
    logic                  w_hash_start;
    logic                  w_data_valid;
    logic                  w_reseed_req;
    logic                  w_busy;

    assign w_at_limit  = (r_block_count == CNT_W'(RESEED_INTERVAL));

    // Only the registered request flag is considered, so a request arriving
    // in READY is delivered two cycles later, never in the same cycle.
    assign w_want_hash = r_pending || (PREFETCH_EN && !w_slot_vld);

    // ------------------------------------------------------------------
    // Block slot: filled from the hash core, emptied on delivery or reseed.
    // hash_done is only honoured in WAIT_HASH, which also drops results of
    // computations abandoned by a reset (the FSM restarts in IDLE).
    // ------------------------------------------------------------------
    assign w_slot_load  = (r_state == ST_WAIT_HASH) && hash_done;
    assign w_slot_clear = (r_state == ST_DELIVER) ||
                          ((r_state == ST_RESEED) && reseed_ack);

    drbg_block_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_block_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_slot_load),
        .i_dat   (hash_digest),
        .i_clear (w_slot_clear),
        .o_dat   (w_slot_dat),
        .o_vld   (w_slot_vld)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_hash_start = 1'b0;
        w_data_valid = 1'b0;
        w_reseed_req = 1'b0;
        w_busy       = 1'b1;

        case (r_state)
            ST_IDLE: begin
                // An exhausted interval always reseeds first; a request
                // that arrived meanwhile stays pending and is served after.
                if (w_at_limit) begin
                    w_next_state = ST_RESEED;
                end else if (w_want_hash) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_hash_start = 1'b1;
                w_next_state = ST_WAIT_HASH;
            end
            ST_WAIT_HASH: begin
                if (hash_done) begin
                    w_next_state = ST_READY;
                end
            end
            ST_READY: begin
                if (r_pending) begin
                    w_next_state = ST_DELIVER;
                end else begin
                    w_busy = 1'b0;
                end
            end
            ST_DELIVER: begin
                w_data_valid = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_RESEED: begin
                w_reseed_req = 1'b1;
                if (reseed_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-deep request flag. Clearing in DELIVER wins, so a request landing
    // in the delivery cycle is treated as a duplicate of the one served.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (r_state == ST_DELIVER) begin
            r_pending <= 1'b0;
        end else if (need_next) begin
            r_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Delivered-block counter, saturating at the reseed interval.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_block_count <= '0;
        end else if ((r_state == ST_RESEED) && reseed_ack) begin
            r_block_count <= '0;
        end else if ((r_state == ST_DELIVER) && !w_at_limit) begin
            r_block_count <= r_block_count + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output block register. It is loaded on the edge entering DELIVER so
    // the new value is already on data_out in the data_valid cycle, and it
    // is otherwise untouched so the consumer can read it at leisure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if ((r_state == ST_READY) && r_pending) begin
            r_data_out <= w_slot_dat;
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = w_data_valid;
    assign busy        = w_busy;
    assign hash_start  = w_hash_start;
    assign reseed_req  = w_reseed_req;
    assign block_count = r_block_count;

endmodule

// File: doc/drbg_producer.md
DRBG_PRODUCER -- requirements
Module: drbg_producer

Interface
REQ-001 Parameter DATA_WIDTH, default 256: width of one generated block.
REQ-002 Parameter RESEED_INTERVAL, default 1024: number of blocks delivered between mandatory reseeds.
REQ-003 Port clk  input  1: clock; reset reset_n, asynchronous, active-low.
REQ-004 Port reset_n  input  1: asynchronous active-low reset.
REQ-005 Port need_next  input  1: single-cycle block request pulse from the consumer.
REQ-006 Port data_out  output  DATA_WIDTH: block presented to the consumer.
REQ-007 Port data_valid  output  1: single-cycle pulse; data_out is valid from this cycle on.
REQ-008 Port busy  output  1: producer cannot accept need_next without delay.
REQ-009 Port hash_start  output  1: single-cycle pulse starting one hash core computation.
REQ-010 Port hash_digest  input  DATA_WIDTH: hash core result.
REQ-011 Port hash_done  input  1: single-cycle pulse; hash_digest is valid in that cycle.
REQ-012 Port reseed_req  output  1: level; held high until reseed_ack.
REQ-013 Port reseed_ack  input  1: single-cycle pulse ending a reseed.
REQ-014 Port block_count  output  $clog2(RESEED_INTERVAL+1): blocks delivered since the last reseed.

Function
REQ-015 FSM states: IDLE, START, WAIT_HASH, READY, DELIVER, RESEED.
REQ-016 IDLE -> RESEED when block_count == RESEED_INTERVAL; else -> START when a request is pending or the prefetch slot is empty.
REQ-017 START drives hash_start high for exactly one cycle, then -> WAIT_HASH.
REQ-018 WAIT_HASH captures hash_digest into the internal block register on hash_done, then -> READY.
REQ-019 READY with a pending request -> DELIVER; otherwise stays in READY.
REQ-020 DELIVER copies the block register to data_out, pulses data_valid, increments block_count, marks the slot empty, then -> IDLE.
REQ-021 RESEED holds reseed_req high; on reseed_ack it clears block_count to 0 and discards the block register, then -> IDLE.
REQ-022 A need_next pulse in any state sets a one-deep pending flag; DELIVER clears it; a second need_next while pending is ignored.
REQ-023 data_out SHALL remain stable from data_valid until the next data_valid (the consumer reads it over many cycles).
REQ-024 busy SHALL be low only in READY with no pending request; high in all other states.
REQ-025 need_next coinciding with the cycle block_count reaches RESEED_INTERVAL: reseed completes first, then the request is served.
REQ-026 hash_done outside WAIT_HASH SHALL be ignored.
REQ-027 block_count saturates at RESEED_INTERVAL and never wraps.

Reset
REQ-028 Reset values: data_out 0, data_valid 0, busy 1, hash_start 0, reseed_req 0, block_count 0, pending 0, state IDLE.
REQ-029 Reset asserted mid-hash discards the computation; a hash_done arriving after reset release SHALL be ignored unless a new hash_start has been issued.

Configuration
REQ-030 With macro DRBG_PRODUCER_PREFETCH_EN defined, IDLE SHALL start a hash with no request pending, so one block is always ready; need_next in READY yields data_valid 2 cycles later.
REQ-031 Without DRBG_PRODUCER_PREFETCH_EN, IDLE SHALL start a hash only when a request is pending; data_valid follows hash_done by 2 cycles.

Structure
REQ-032 Shared package drbg_pkg SHALL hold the FSM state encoding, the DATA_WIDTH default and the RESEED_INTERVAL default, and SHALL also be used by drbg_consumer.
REQ-033 A single sub-module, drbg_block_reg, SHALL implement the block register with load, valid-flag and clear; the FSM stays in drbg_producer.

Verification
REQ-034 With prefetch on: after reset, hash_done with digest 0xA5..A5; then need_next at cycle T -> data_valid at T+2, data_out=0xA5..A5, block_count=1.
REQ-035 With prefetch off: need_next -> exactly one hash_start; hash_done at cycle H -> data_valid at H+2; busy high from need_next until the cycle after data_valid.
REQ-036 RESEED_INTERVAL=4: the 5th need_next raises reseed_req; reseed_ack -> block_count=0, then the block is delivered.
REQ-037 Two need_next pulses 3 cycles apart while in WAIT_HASH -> exactly one data_valid; a stray hash_done in READY leaves data_out unchanged.
REQ-038 reset_n low for 1 cycle during WAIT_HASH: outputs at reset values; a late hash_done is ignored; the next need_next is served normally.
